tone_seq_gen: RTL and testbench

Parametrised note player for the buzzer path. Accepts one note at a time (period, duty, duration) over a valid/ready handshake and drives a PWM waveform on `been` for exactly the requested duration. It then returns to idle and pulses `note_done`. It sits between the melody/score sequencer and the buzzer pin, clocked by the 1 MHz system tick. It adds programmable duty, rests, note duration and abort on top of the single fixed-square-wave divider.

---
 rtl/tone_seq_gen_if.sv | 25 ++
 rtl/tone_seq_gen.sv | 91 +++++++++
 tb/tb_tone_seq_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tone_seq_gen_if.sv
// tone_seq_gen_if: note handshake, control and buzzer output bundle for tone_seq_gen
interface tone_seq_gen_if #(
    parameter int CNT_W = 16,
    parameter int DUR_W = 16
);
    logic             note_valid;
    logic             note_ready;
    logic [CNT_W-1:0] note_div;
    logic [CNT_W-1:0] note_duty;
    logic [DUR_W-1:0] note_dur;
    logic             stop;
    logic             busy;
    logic             note_done;
    logic             been;

    modport master (
        output note_valid, note_div, note_duty, note_dur, stop,
        input  note_ready, busy, note_done, been
    );

    modport slave (
        input  note_valid, note_div, note_duty, note_dur, stop,
        output note_ready, busy, note_done, been
    );
endinterface

// File: rtl/tone_seq_gen.sv
// tone_seq_gen: plays one note at a time as a PWM waveform on been for dur*TICK_DIV cycles
module tone_seq_gen #(
    parameter int CNT_W    = 16,
    parameter int DUR_W    = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic           clk_1mhz,
    input  logic           rst_n,
    tone_seq_gen_if.slave  bus
);
    localparam int TW = $clog2(TICK_DIV + 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_duty;
    logic [DUR_W-1:0] r_dur;
    logic [CNT_W-1:0] r_cnt;
    logic [TW-1:0]    r_tick;
    logic [DUR_W-1:0] r_dcnt;
    logic             r_been;
    logic             r_done;
    logic             w_ready;
    logic             w_accept;
    logic             w_tick_end;
    logic             w_end;
    logic             w_pwm;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W:0]   w_duty_eff;

    assign w_ready    = (r_state == IDLE) && !bus.stop;
    assign w_accept   = bus.note_valid && w_ready;
    assign w_sum      = {1'b0, r_div} + (CNT_W+1)'(1);
    assign w_duty_eff = (r_duty == '0) ? (w_sum >> 1) : {1'b0, r_duty};
    assign w_pwm      = (r_div != '0) && ({1'b0, r_cnt} < w_duty_eff);
    assign w_tick_end = r_tick == TW'(TICK_DIV - 1);
    assign w_end      = (r_dur == '0) ||
                        (w_tick_end && ({1'b0, r_dcnt} == {1'b0, r_dur} - (DUR_W+1)'(1)));

    assign bus.note_ready = w_ready;
    assign bus.busy       = r_state == PLAY;
    assign bus.note_done  = r_done;
    assign bus.been       = r_been;

    // state register
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state: accept starts a note, stop or end of duration returns to idle
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = w_accept ? PLAY : IDLE;
        else                 w_next = (bus.stop || w_end) ? IDLE : PLAY;
    end

    // note fields, period/duration counters and registered outputs
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_duty <= '0;
            r_dur  <= '0;
            r_cnt  <= '0;
            r_tick <= '0;
            r_dcnt <= '0;
            r_been <= 1'b0;
            r_done <= 1'b0;
        end else if (w_accept) begin
            r_div  <= bus.note_div;
            r_duty <= bus.note_duty;
            r_dur  <= bus.note_dur;
            r_cnt  <= '0;
            r_tick <= '0;
            r_dcnt <= '0;
            r_been <= 1'b0;
            r_done <= 1'b0;
        end else if (r_state == PLAY && !w_end && !bus.stop) begin
            r_been <= w_pwm;
            r_cnt  <= (r_cnt == r_div) ? '0 : r_cnt + CNT_W'(1);
            r_tick <= w_tick_end ? '0 : r_tick + TW'(1);
            r_dcnt <= w_tick_end ? r_dcnt + DUR_W'(1) : r_dcnt;
            r_done <= 1'b0;
        end else begin
            r_been <= 1'b0;
            r_done <= (r_state == PLAY) && w_end && !bus.stop;
        end
    end
endmodule

// File: tb/tb_tone_seq_gen.sv
// tb_tone_seq_gen: directed scoreboard bench for tone_seq_gen with TICK_DIV=4
module tb_tone_seq_gen;
    localparam int CNT_W = 4;
    localparam int DUR_W = 8;
    localparam int TD    = 4;

    typedef struct packed {
        logic been;
        logic busy;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];

    tone_seq_gen_if #(.CNT_W(CNT_W), .DUR_W(DUR_W)) bus ();

    tone_seq_gen #(.CNT_W(CNT_W), .DUR_W(DUR_W), .TICK_DIV(TD)) dut (
        .clk_1mhz (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // expected outputs after E0 and after each PLAY edge E1..EN, from the closed-form waveform
    task automatic push_note(input int div, input int duty, input int dur);
        exp_t e;
        int   n;
        int   deff;
        n    = (dur == 0) ? 1 : dur * TD;
        deff = (duty == 0) ? (div + 1) / 2 : duty;
        e = '{been: 1'b0, busy: 1'b1, done: 1'b0};
        q.push_back(e);
        for (int k = 1; k <= n; k++) begin
            if (k == n) e = '{been: 1'b0, busy: 1'b0, done: 1'b1};
            else        e = '{been: (div != 0) && (((k - 1) % (div + 1)) < deff), busy: 1'b1, done: 1'b0};
            q.push_back(e);
        end
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) q.push_back('{been: 1'b0, busy: 1'b0, done: 1'b0});
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                check("queue_empty", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                check("been", bus.been, e.been);
                check("busy", bus.busy, e.busy);
                check("note_done", bus.note_done, e.done);
            end
        end
    endtask

    task automatic drive(input int div, input int duty, input int dur);
        bus.note_div   = CNT_W'(div);
        bus.note_duty  = CNT_W'(duty);
        bus.note_dur   = DUR_W'(dur);
        bus.note_valid = 1'b1;
    endtask

    task automatic play(input int div, input int duty, input int dur);
        drive(div, duty, dur);
        push_note(div, duty, dur);
        run(1);
        bus.note_valid = 1'b0;
        bus.note_div   = '1;
        bus.note_duty  = '1;
        run((dur == 0) ? 1 : dur * TD);
    endtask

    initial begin
        bus.note_valid = 1'b0;
        bus.note_div   = '0;
        bus.note_duty  = '0;
        bus.note_dur   = '0;
        bus.stop       = 1'b0;
        #12;
        check("rst_been", bus.been, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.note_done, 1'b0);
        check("rst_ready", bus.note_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        play(3, 0, 2);
        check("ready_after_end", bus.note_ready, 1'b1);
        play(4, 1, 1);
        play(2, 5, 1);
        play(0, 0, 3);
        play(15, 0, 2);

        drive(3, 0, 0);
        push_note(3, 0, 0);
        run(1);
        drive(1, 0, 1);
        push_note(1, 0, 1);
        check("ready_in_play", bus.note_ready, 1'b0);
        run(1);
        check("ready_after_dur0", bus.note_ready, 1'b1);
        run(1);
        bus.note_valid = 1'b0;
        run(TD);

        drive(3, 0, 3);
        push_note(3, 0, 3);
        run(1);
        bus.note_valid = 1'b0;
        run(4);
        q.delete();
        bus.stop = 1'b1;
        push_idle(1);
        run(1);
        drive(3, 0, 1);
        #1;
        check("ready_stop", bus.note_ready, 1'b0);
        push_idle(3);
        run(3);
        bus.note_valid = 1'b0;
        bus.stop = 1'b0;
        #1;
        check("ready_stop_released", bus.note_ready, 1'b1);

        play(3, 0, 1);

        drive(3, 0, 2);
        push_note(3, 0, 2);
        run(1);
        bus.note_valid = 1'b0;
        run(2);
        q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_been", bus.been, 1'b0);
        check("async_busy", bus.busy, 1'b0);
        check("async_done", bus.note_done, 1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        play(3, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
